bcd_digit_entry: RTL and testbench

- Reads decimal digits typed on board switches and committed with a key press, and builds the binary value they represent.
- This is the reverse path of the hex score display, which splits binary into decimal digits; this block folds decimal digits back into binary.
- It feeds game setup: target level, entered high-score thresholds, and similar values.
- Holds a shift buffer of BCD digits and echoes it for the HEX displays. A sequential multiply-by-ten-and-add engine produces the binary value on commit.

---
 rtl/bcd_digit_entry_if.sv | 28 ++
 rtl/bcd_digit_entry.sv | 173 +++++++++++++++++
 tb/tb_bcd_digit_entry.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_entry_if.sv
// Switch/key entry bus for the BCD digit entry block.
// The master side drives the switch and key levels; the slave side returns
// the digit buffer echo, the converted value and the status pulses.
interface bcd_digit_entry_if #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
);
    logic [3:0]              digit_in;
    logic                    digit_push;
    logic                    clear;
    logic                    commit;
    logic [4*NUM_DIGITS-1:0] bcd_digits;
    logic [2:0]              digit_count;
    logic [OUT_W-1:0]        value;
    logic                    value_valid;
    logic                    busy;
    logic                    entry_error;

    modport master (
        output digit_in, digit_push, clear, commit,
        input  bcd_digits, digit_count, value, value_valid, busy, entry_error
    );

    modport slave (
        input  digit_in, digit_push, clear, commit,
        output bcd_digits, digit_count, value, value_valid, busy, entry_error
    );
endinterface

// File: rtl/bcd_digit_entry.sv
// Decimal digit entry: collects BCD digits from switches into a shift buffer
// and, on commit, folds them into a binary value with a sequential
// multiply-by-ten-and-add engine (one digit per cycle, MSD first).
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  COLLECT | accepting push/clear/commit edges, buffer echoed on displays
//  CONVERT | acc = acc*10 + digit[idx], one digit per cycle, inputs ignored
//  DONE    | publish acc as value, pulse value_valid, empty the buffer
module bcd_digit_entry #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    bcd_digit_entry_if.slave      bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    push_q;
    logic                    clear_q;
    logic                    commit_q;
    logic                    push_edge;
    logic                    clear_edge;
    logic                    commit_edge;

    logic [4*NUM_DIGITS-1:0] digits;
    logic [4*NUM_DIGITS-1:0] digits_nxt;
    logic [2:0]              count;
    logic [2:0]              count_nxt;
    logic [OUT_W-1:0]        acc;
    logic [OUT_W-1:0]        acc_nxt;
    logic [OUT_W-1:0]        acc_x10;
    logic [OUT_W-1:0]        value_r;
    logic [OUT_W-1:0]        value_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [3:0]              cur_digit;
    logic                    busy_r;
    logic                    busy_nxt;
    logic                    valid_r;
    logic                    valid_nxt;
    logic                    err_r;
    logic                    err_nxt;

    // Edges act at the same clock edge that first samples the high level.
    assign push_edge   = bus.digit_push & ~push_q;
    assign clear_edge  = bus.clear      & ~clear_q;
    assign commit_edge = bus.commit     & ~commit_q;

    // Edge-detect registers track their inputs in every state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            push_q   <= 1'b0;
            clear_q  <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            push_q   <= bus.digit_push;
            clear_q  <= bus.clear;
            commit_q <= bus.commit;
        end
    end

    // Multiply-by-ten as shift-and-add; the parameter rule keeps it in range.
    always_comb begin
        cur_digit = digits[{idx, 2'b00} +: 4];
        acc_x10   = (acc << 3) + (acc << 1);
    end

    // Next-state and datapath next values; everything holds by default.
    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        count_nxt  = count;
        acc_nxt    = acc;
        idx_nxt    = idx;
        value_nxt  = value_r;
        busy_nxt   = busy_r;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            COLLECT: begin
                if (clear_edge) begin
                    digits_nxt = '0;
                    count_nxt  = 3'd0;
                end else if (commit_edge) begin
                    acc_nxt   = '0;
                    idx_nxt   = IDX_W'(NUM_DIGITS - 1);
                    busy_nxt  = 1'b1;
                    state_nxt = CONVERT;
                end else if (push_edge) begin
                    // Rejected pushes never touch the buffer: no wrap on full.
                    if (bus.digit_in > 4'd9 || count == 3'(NUM_DIGITS)) begin
                        err_nxt = 1'b1;
                    end else begin
                        digits_nxt = {digits[4*NUM_DIGITS-5:0], bus.digit_in};
                        count_nxt  = count + 3'd1;
                    end
                end
            end
            CONVERT: begin
                acc_nxt = acc_x10 + OUT_W'(cur_digit);
                idx_nxt = idx - IDX_W'(1);
                if (idx == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                value_nxt  = acc;
                valid_nxt  = 1'b1;
                digits_nxt = '0;
                count_nxt  = 3'd0;
                state_nxt  = COLLECT;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = COLLECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            digits  <= '0;
            count   <= 3'd0;
            acc     <= '0;
            idx     <= '0;
            value_r <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            digits  <= digits_nxt;
            count   <= count_nxt;
            acc     <= acc_nxt;
            idx     <= idx_nxt;
            value_r <= value_nxt;
            busy_r  <= busy_nxt;
            valid_r <= valid_nxt;
            err_r   <= err_nxt;
        end
    end

    assign bus.bcd_digits  = digits;
    assign bus.digit_count = count;
    assign bus.value       = value_r;
    assign bus.value_valid = valid_r;
    assign bus.busy        = busy_r;
    assign bus.entry_error = err_r;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry: hand-computed buffer contents,
// conversion results and cycle-exact busy/value_valid timing.
module tb_bcd_digit_entry;

    logic CLOCK_50;
    logic resetn;
    int   checks;
    int   errors;
    int   pulses;

    bcd_digit_entry_if #(.NUM_DIGITS(4), .OUT_W(14)) bus ();

    bcd_digit_entry #(.NUM_DIGITS(4), .OUT_W(14)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_digit(input logic [3:0] d, input logic exp_err);
        bus.digit_in   = d;
        bus.digit_push = 1'b1;
        tick();
        chk("push_err", 32'(bus.entry_error), 32'(exp_err));
        bus.digit_push = 1'b0;
        tick();
        chk("err_one_cycle", 32'(bus.entry_error), 32'd0);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
    endtask

    // Commit edge at T: busy for T..T+4, value/value_valid at T+5.
    task automatic do_commit(input logic [31:0] exp_val);
        bus.commit = 1'b1;
        tick();
        chk("busy_start", 32'(bus.busy), 32'd1);
        bus.commit = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("busy_conv", 32'(bus.busy), 32'd1);
            chk("no_early_valid", 32'(bus.value_valid), 32'd0);
        end
        tick();
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("valid_not_yet", 32'(bus.value_valid), 32'd0);
        tick();
        chk("valid_pulse", 32'(bus.value_valid), 32'd1);
        chk("value", 32'(bus.value), exp_val);
        chk("count_after", 32'(bus.digit_count), 32'd0);
        chk("digits_after", 32'(bus.bcd_digits), 32'd0);
        tick();
        chk("valid_drop", 32'(bus.value_valid), 32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        bus.digit_in   = 4'd0;
        bus.digit_push = 1'b0;
        bus.clear      = 1'b0;
        bus.commit     = 1'b0;
        resetn         = 1'b0;
        repeat (3) tick();
        chk("rst_digits", 32'(bus.bcd_digits), 32'd0);
        chk("rst_count", 32'(bus.digit_count), 32'd0);
        chk("rst_value", 32'(bus.value), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.value_valid), 32'd0);
        resetn = 1'b1;
        tick();

        // 1,2,3,4 -> 1234
        push_digit(4'd1, 1'b0);
        push_digit(4'd2, 1'b0);
        push_digit(4'd3, 1'b0);
        push_digit(4'd4, 1'b0);
        chk("buf_1234", 32'(bus.bcd_digits), 32'h1234);
        chk("cnt_1234", 32'(bus.digit_count), 32'd4);
        do_commit(32'd1234);

        // 0,7 -> 7 ; 9999 -> 0x270F
        push_digit(4'd0, 1'b0);
        push_digit(4'd7, 1'b0);
        chk("buf_07", 32'(bus.bcd_digits), 32'h0007);
        do_commit(32'd7);
        for (int i = 0; i < 4; i++) push_digit(4'd9, 1'b0);
        do_commit(32'h270F);
        chk("value_hold", 32'(bus.value), 32'h270F);

        // Full buffer and non-decimal digit are rejected
        for (int i = 0; i < 4; i++) push_digit(4'd5, 1'b0);
        push_digit(4'd5, 1'b1);
        chk("buf_full", 32'(bus.bcd_digits), 32'h5555);
        chk("cnt_full", 32'(bus.digit_count), 32'd4);
        push_digit(4'hB, 1'b1);
        chk("buf_after_B", 32'(bus.bcd_digits), 32'h5555);
        pulse_clear();
        push_digit(4'hA, 1'b1);
        chk("cnt_after_A", 32'(bus.digit_count), 32'd0);

        // Clear beats a simultaneous push, silently; clear keeps value
        push_digit(4'd4, 1'b0);
        push_digit(4'd2, 1'b0);
        chk("buf_42", 32'(bus.bcd_digits), 32'h0042);
        bus.digit_in   = 4'd6;
        bus.digit_push = 1'b1;
        bus.clear      = 1'b1;
        tick();
        chk("clr_push_err", 32'(bus.entry_error), 32'd0);
        chk("clr_digits", 32'(bus.bcd_digits), 32'd0);
        chk("clr_count", 32'(bus.digit_count), 32'd0);
        chk("clr_value", 32'(bus.value), 32'h270F);
        bus.digit_push = 1'b0;
        bus.clear      = 1'b0;
        tick();
        do_commit(32'd0);

        // Inputs toggled during CONVERT of 0042 are ignored
        push_digit(4'd4, 1'b0);
        push_digit(4'd2, 1'b0);
        bus.commit = 1'b1;
        tick();
        chk("busy_42", 32'(bus.busy), 32'd1);
        bus.commit     = 1'b0;
        bus.digit_in   = 4'hC;
        bus.digit_push = 1'b1;
        bus.clear      = 1'b1;
        tick();
        chk("conv_no_err", 32'(bus.entry_error), 32'd0);
        chk("conv_buf_frozen", 32'(bus.bcd_digits), 32'h0042);
        bus.digit_push = 1'b0;
        bus.clear      = 1'b0;
        bus.commit     = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        tick();
        chk("busy_42_end", 32'(bus.busy), 32'd0);
        tick();
        chk("valid_42", 32'(bus.value_valid), 32'd1);
        chk("value_42", 32'(bus.value), 32'd42);
        tick();
        chk("busy_42_idle", 32'(bus.busy), 32'd0);
        chk("valid_42_drop", 32'(bus.value_valid), 32'd0);

        // Commit held for 20 cycles gives exactly one conversion
        push_digit(4'd8, 1'b0);
        pulses     = 0;
        bus.commit = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.value_valid) pulses++;
        end
        bus.commit = 1'b0;
        tick();
        chk("held_commit_pulses", 32'(pulses), 32'd1);
        chk("held_commit_value", 32'(bus.value), 32'd8);

        // Reset in the second CONVERT cycle of 8765
        push_digit(4'd8, 1'b0);
        push_digit(4'd7, 1'b0);
        push_digit(4'd6, 1'b0);
        push_digit(4'd5, 1'b0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_value", 32'(bus.value), 32'd0);
        chk("mid_rst_digits", 32'(bus.bcd_digits), 32'd0);
        chk("mid_rst_count", 32'(bus.digit_count), 32'd0);
        pulses = 0;
        repeat (2) begin
            tick();
            if (bus.value_valid) pulses++;
        end
        resetn = 1'b1;
        repeat (8) begin
            tick();
            if (bus.value_valid) pulses++;
        end
        chk("mid_rst_no_valid", 32'(pulses), 32'd0);
        chk("mid_rst_busy_after", 32'(bus.busy), 32'd0);
        push_digit(4'd3, 1'b0);
        do_commit(32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
